// File: rtl/pmpd_spi_master_pkg.sv
// Shared definitions for the PMPD sensor-state SPI master: frame geometry,
// byte-lane positions, FSM state encoding and the frame packing helper.
package pmpd_spi_pkg;

  localparam int FRAME_BITS = 64;
  localparam int PEDAL_MSB  = 31;
  localparam int EXPR_MSB   = 23;
  localparam int BPM_MSB    = 15;
  localparam int RR_MSB     = 7;
  localparam int BIT_CNT_W  = 7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [7:0] pedal,
    input logic [7:0] expression,
    input logic [7:0] bpm,
    input logic [7:0] rr
  );
    logic [FRAME_BITS-1:0] frame;
    frame = '0;
    frame[PEDAL_MSB -: 8] = pedal;
    frame[EXPR_MSB  -: 8] = expression;
    frame[BPM_MSB   -: 8] = bpm;
    frame[RR_MSB    -: 8] = rr;
    return frame;
  endfunction

endpackage

// File: rtl/pmpd_spi_master_if.sv
// Host-side request/status signals and SPI pins of the PMPD SPI master.
// The master modport is the RTL view; the slave modport is the peer/host view.
interface pmpd_spi_master_if;
  import pmpd_spi_pkg::*;

  logic                  start;
  logic [7:0]            pedal;
  logic [7:0]            expression;
  logic [7:0]            bpm;
  logic [7:0]            rr;
  logic                  sclk;
  logic                  mosi;
  logic                  ss;
  logic                  miso;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_data;

  modport master (
    input  start, pedal, expression, bpm, rr, miso,
    output sclk, mosi, ss, busy, done, rx_data
  );

  modport slave (
    output start, pedal, expression, bpm, rr, miso,
    input  sclk, mosi, ss, busy, done, rx_data
  );

endinterface

// File: rtl/pmpd_spi_master_clk_gen.sv
// SPI clock generator: half-period counter with sclk level, rise/fall strobes
// and a half_done strobe that the FSM also uses to time its fixed waits.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic half_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    half_done = en && (cnt_q == CW'(CLK_DIV - 1));
    rise      = half_done && toggle_en && !sclk_q;
    fall      = half_done && toggle_en && sclk_q;
    cnt_d     = cnt_q;
    if (!en || half_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Outside SHIFT the clock is forced low so it always idles at 0.
    sclk_d = toggle_en ? (sclk_q ^ half_done) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/pmpd_spi_master.sv
// PMPD SPI master (mode 0, MSB first): sends one 64-bit sensor frame and captures
// the 64-bit MISO reply. Define PMPD_SPI_AUTO_EN to add a free-running auto start.
module pmpd_spi_master
  import pmpd_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
`ifdef PMPD_SPI_AUTO_EN
  ,
  parameter int AUTO_PERIOD = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pmpd_spi_master_if.master   bus
);

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [FRAME_BITS-1:0]  rx_q, rx_d;
  logic [FRAME_BITS-1:0]  rx_data_q, rx_data_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic                   ss_q, ss_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   frame_active;
  logic                   auto_start;
  logic                   start_req;
  logic                   sclk, rise, fall, half_done;

`ifdef PMPD_SPI_AUTO_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;

  // A request fires whenever the counter sits at zero, i.e. right out of reset
  // and after every wrap; it is dropped if a frame is already in flight.
  always_comb begin
    auto_start = (auto_cnt_q == '0);
    auto_cnt_d = (auto_cnt_q == AW'(AUTO_PERIOD - 1)) ? '0 : auto_cnt_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) auto_cnt_q <= '0;
    else     auto_cnt_q <= auto_cnt_d;
  end
`else
  assign auto_start = 1'b0;
`endif

  assign start_req = bus.start | auto_start;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != IDLE),
    .toggle_en (state_q == SHIFT),
    .sclk      (sclk),
    .rise      (rise),
    .fall      (fall),
    .half_done (half_done)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    bit_d     = bit_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          tx_d    = build_frame(bus.pedal, bus.expression, bus.bpm, bus.rr);
          rx_d    = '0;
          bit_d   = BIT_CNT_W'(FRAME_BITS - 1);
          state_d = SETUP;
        end
      end
      SETUP: if (half_done) state_d = SHIFT;
      SHIFT: begin
        if (rise) rx_d = {rx_q[FRAME_BITS-2:0], bus.miso};
        if (fall) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          // Bit 0 ends the shift phase; the counter never wraps to a 65th bit.
          if (bit_q == '0) state_d = HOLD;
          else             bit_d   = bit_q - BIT_CNT_W'(1);
        end
      end
      HOLD: begin
        if (half_done) begin
          state_d   = GAP;
          rx_data_d = rx_q;
        end
      end
      GAP:     if (half_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_active = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
    ss_d   = !frame_active;
    mosi_d = frame_active ? tx_d[FRAME_BITS-1] : 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_q == HOLD) && (state_d == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk;
  assign bus.ss      = ss_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_pmpd_spi_master.sv
// Bench for pmpd_spi_master: a mode-0 slave model decodes MOSI and drives MISO,
// a scoreboard queue holds expected frames and a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_pmpd_spi_master;
  import pmpd_spi_pkg::*;

`ifdef PMPD_SPI_AUTO_EN
  localparam int CLK_DIV     = 2;
  localparam int AUTO_PERIOD = 1000;
`else
  localparam int CLK_DIV     = 4;
`endif
  localparam int SS_LOW_CYC = 130 * CLK_DIV;

  typedef struct {
    logic [63:0] tx;
    logic [63:0] rx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmpd_spi_master_if bus();

  pmpd_spi_master #(
    .CLK_DIV(CLK_DIV)
`ifdef PMPD_SPI_AUTO_EN
    ,
    .AUTO_PERIOD(AUTO_PERIOD)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  // Slave model state
  logic [63:0] slv_word = '0;
  logic [63:0] slv_tx_sh = '0;
  logic [63:0] slv_rx_sh = '0;
  int          slv_edges = 0;
  int          slv_low   = 0;
  logic        slv_bad   = 1'b0;
  logic        hold_mosi = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_ss   = 1'b1;
  logic [63:0] last_rx   = '0;
  int          last_edges = 0;
  int          last_low   = 0;
  logic        last_bad   = 1'b0;
  int          last_fall  = 0;
  int          prev_fall  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model and scoreboard monitor share one process so the slave's view of a
  // frame is complete before the done pulse of that frame is judged.
  always @(negedge clk) begin
    if (prev_ss === 1'b1 && bus.ss === 1'b0) begin
      slv_tx_sh = slv_word;
      slv_rx_sh = '0;
      slv_edges = 0;
      slv_low   = 0;
      slv_bad   = 1'b0;
      prev_fall = last_fall;
      last_fall = cyc;
    end
    if (bus.ss === 1'b0) begin
      slv_low++;
      if (!prev_sclk && bus.sclk) begin
        slv_rx_sh = {slv_rx_sh[62:0], bus.mosi};
        slv_edges++;
        hold_mosi = bus.mosi;
      end else if (bus.sclk && bus.mosi !== hold_mosi) begin
        slv_bad = 1'b1;
      end
      if (prev_sclk && !bus.sclk) slv_tx_sh = slv_tx_sh << 1;
      bus.miso = slv_tx_sh[63];
    end
    if (prev_ss === 1'b0 && bus.ss === 1'b1) begin
      last_rx    = slv_rx_sh;
      last_edges = slv_edges;
      last_low   = slv_low;
      last_bad   = slv_bad;
    end
    prev_ss   = bus.ss;
    prev_sclk = bus.sclk;

    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done_cnt), 64'(done_cnt - 1));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame %0d done @%0d: rx_data=%h mosi_frame=%h edges=%0d ss_low=%0d",
                 done_cnt, cyc, bus.rx_data, last_rx, last_edges, last_low);
        check("rx_data", bus.rx_data, e.rx);
        check("mosi_frame", last_rx, e.tx);
        check("sclk_edges", 64'(last_edges), 64'(64));
        check("ss_low_cycles", 64'(last_low), 64'(SS_LOW_CYC));
        check("mosi_stable_high", 64'(last_bad), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] p, input logic [7:0] e, input logic [7:0] b,
                          input logic [7:0] r);
    bus.pedal      = p;
    bus.expression = e;
    bus.bpm        = b;
    bus.rr         = r;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] e, input logic [7:0] b,
                      input logic [7:0] r, input logic [63:0] sw, input logic [63:0] exp_tx);
    exp_t x;
    set_data(p, e, b, r);
    slv_word = sw;
    x.tx = exp_tx;
    x.rx = sw;
    exp_q.push_back(x);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 3000);
    if (bus.done !== 1'b1) check(name, 64'(0), 64'(1));
  endtask

  task automatic wait_ss_low(output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ss !== 1'b0 && n < 3000);
    if (bus.ss !== 1'b0) check("ss_fall_timeout", 64'(bus.ss), 64'(0));
    at_cyc = cyc;
  endtask

  initial begin
    int f1, f2, n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.miso  = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);

`ifdef PMPD_SPI_AUTO_EN
    begin
      exp_t x;
      set_data(8'h21, 8'h43, 8'h65, 8'h87);
      slv_word = 64'h0000_0000_0000_0002;
      for (int i = 0; i < 3; i++) begin
        x.tx = 64'h00000000_21436587;
        x.rx = slv_word;
        exp_q.push_back(x);
      end
      repeat (10) tick();
      check("auto_reset_busy", 64'(bus.busy), 64'(0));
      rst = 1'b0;
      repeat (2900) tick();
      check("auto_done_count", 64'(done_cnt), 64'(3));
      check("auto_frame_spacing", 64'(last_fall - prev_fall), 64'(AUTO_PERIOD));
    end
`else
    // Reset held with start asserted: everything must stay idle.
    bus.start = 1'b1;
    repeat (10) tick();
    check("reset_sclk", 64'(bus.sclk), 64'(0));
    check("reset_ss", 64'(bus.ss), 64'(1));
    check("reset_mosi", 64'(bus.mosi), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_rx_data", bus.rx_data, 64'h0);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check("idle_busy", 64'(bus.busy), 64'(0));

    // Basic frame; MISO reply pm=1; busy drop after done.
    send(8'hA5, 8'h01, 8'h48, 8'h10, 64'h0000_0000_0000_0001, 64'h00000000_A5014810);
    check("busy_after_start", 64'(bus.busy), 64'(1));
    wait_done("done_timeout_basic");
    repeat (CLK_DIV - 1) @(negedge clk);
    check("busy_held_in_gap", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("busy_dropped", 64'(bus.busy), 64'(0));
    repeat (5) tick();

    // Start pulsed mid-frame with different data is ignored.
    send(8'h3C, 8'h7E, 8'h5A, 8'h0F, 64'hDEADBEEF_0123ABCD, 64'h00000000_3C7E5A0F);
    repeat (98) tick();
    set_data(8'hFF, 8'hEE, 8'hDD, 8'hCC);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("done_timeout_ignore");
    repeat (700) tick();
    check("done_count_after_ignore", 64'(done_cnt), 64'(2));

    // Start held high: second frame accepted exactly when busy has dropped.
    begin
      exp_t x;
      set_data(8'h12, 8'h34, 8'h56, 8'h78);
      slv_word = 64'hF0F0_0F0F_8001_7FFE;
      x.tx = 64'h00000000_12345678;
      x.rx = slv_word;
      exp_q.push_back(x);
      exp_q.push_back(x);
    end
    bus.start = 1'b1;
    wait_ss_low(f1);
    wait_done("done_timeout_b2b_1");
    wait_ss_low(f2);
    bus.start = 1'b0;
    check("start_to_start_cycles", 64'(f2 - f1), 64'(131 * CLK_DIV + 1));
    wait_done("done_timeout_b2b_2");
    repeat (10) tick();

    // Reset in the middle of a frame, then a clean frame.
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    slv_word = 64'hAAAA5555_12345678;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (slv_edges < 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit20", 64'(slv_edges >= 20), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("midrst_ss", 64'(bus.ss), 64'(1));
    check("midrst_sclk", 64'(bus.sclk), 64'(0));
    check("midrst_mosi", 64'(bus.mosi), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_rx_data", bus.rx_data, 64'h0);
    rst = 1'b0;
    repeat (CLK_DIV * 4) tick();
    check("midrst_no_done", 64'(done_cnt), 64'(4));
    send(8'h99, 8'h88, 8'h77, 8'h66, 64'h01234567_89ABCDEF, 64'h00000000_99887766);
    wait_done("done_timeout_after_rst");
    repeat (20) tick();
    check("final_done_count", 64'(done_cnt), 64'(5));
`endif
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
